// File: rtl/ofm_tile_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package : ofm_tile_sched_pkg
// Brief   : Shared widths, scheduler state encoding and channel-group helper.
// Rev     : 1.0
// ============================================================================
package ofm_tile_sched_pkg;

    localparam int IDX_W     = 8;
    localparam int IFM_IDX_W = 10;
    localparam int OUT_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

    // 9-bit sum so OFM_C = 255 rounds up without wrapping
    function automatic logic [IDX_W-1:0] calc_ncg(input logic [IDX_W-1:0] ofm_c,
                                                  input int               total_pe);
        logic [8:0] sum;
        sum = {1'b0, ofm_c} + 9'(total_pe - 1);
        return IDX_W'(sum / 9'(total_pe));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ofm_tile_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface : ofm_tile_scheduler_if
// Brief     : Tile descriptor handshake plus per-tile completion pulse.
// Rev       : 1.0
// ============================================================================
interface ofm_tile_scheduler_if;
    import ofm_tile_sched_pkg::*;

    logic                 tile_valid;
    logic                 tile_ready;
    logic [IDX_W-1:0]     tile_row;
    logic [IDX_W-1:0]     tile_col;
    logic [IDX_W-1:0]     tile_cgrp;
    logic [IFM_IDX_W-1:0] ifm_row;
    logic [IFM_IDX_W-1:0] ifm_col;
    logic                 tile_last;
    logic                 pe_done;

    modport master (
        output tile_valid, tile_row, tile_col, tile_cgrp, ifm_row, ifm_col, tile_last,
        input  tile_ready, pe_done
    );

    modport slave (
        input  tile_valid, tile_row, tile_col, tile_cgrp, ifm_row, ifm_col, tile_last,
        output tile_ready, pe_done
    );

endinterface
`default_nettype wire

// File: rtl/ofm_tile_scheduler_tile_index_counter.sv
`default_nettype none
// ============================================================================
// Module : tile_index_counter
// Brief  : Nested col (inner) / row / cgrp (outer) counter with last-tile flag.
// Rev    : 1.0
// ============================================================================
module tile_index_counter
    import ofm_tile_sched_pkg::*;
(
    input  wire              clk,
    input  wire              rst_n,
    input  wire              load,
    input  wire              advance,
    input  wire [IDX_W-1:0]  cfg_w,
    input  wire [IDX_W-1:0]  cfg_ncg,
    output logic [IDX_W-1:0] col,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] cgrp,
    output logic             last
);

    logic [IDX_W-1:0] col_q, col_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] cgrp_q, cgrp_d;
    logic [IDX_W-1:0] w_m1;
    logic [IDX_W-1:0] ncg_m1;

    assign w_m1   = cfg_w - IDX_W'(1);
    assign ncg_m1 = cfg_ncg - IDX_W'(1);

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        cgrp_d = cgrp_q;
        if (load) begin
            col_d  = '0;
            row_d  = '0;
            cgrp_d = '0;
        end else if (advance) begin
            if (col_q == w_m1) begin
                col_d = '0;
                if (row_q == w_m1) begin
                    row_d  = '0;
                    cgrp_d = (cgrp_q == ncg_m1) ? '0 : cgrp_q + IDX_W'(1);
                end else begin
                    row_d = row_q + IDX_W'(1);
                end
            end else begin
                col_d = col_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            cgrp_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            cgrp_q <= cgrp_d;
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign cgrp = cgrp_q;
    assign last = (col_q == w_m1) && (row_q == w_m1) && (cgrp_q == ncg_m1);

endmodule
`default_nettype wire

// File: rtl/ofm_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module : ofm_tile_scheduler
// Brief  : Walks every OFM tile of a layer, throttled by in-flight tile count.
//          Optional perf counters: OFM_TILE_SCHED_PERF_EN.
// Rev    : 1.0
// ============================================================================
module ofm_tile_scheduler
    import ofm_tile_sched_pkg::*;
#(
    parameter int TOTAL_PE        = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  wire               clk,
    input  wire               rst_n,
    input  wire               start,
    input  wire [IDX_W-1:0]   OFM_W,
    input  wire [IDX_W-1:0]   OFM_C,
    input  wire [1:0]         stride,
    ofm_tile_scheduler_if.master tile_bus,
    output logic [OUT_W-1:0]  outstanding,
    output logic              busy,
    output logic              done
`ifdef OFM_TILE_SCHED_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       throttle_cycles
`endif
);

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] w_q, w_d;
    logic [IDX_W-1:0] ncg_q, ncg_d;
    logic [1:0]       s_q, s_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [IDX_W-1:0] ncg_in;
    logic [IDX_W-1:0] idx_col, idx_row, idx_cgrp;
    logic             idx_last;
    logic             start_ok;
    logic             handshake;
    logic             pe_dec;
    logic             at_limit;

    assign ncg_in    = calc_ncg(OFM_C, TOTAL_PE);
    assign start_ok  = (state_q == IDLE) && start;
    assign at_limit  = (out_q >= OUT_W'(MAX_OUTSTANDING));
    assign handshake = tile_bus.tile_valid && tile_bus.tile_ready;
    // A completion with nothing in flight is spurious and dropped
    assign pe_dec    = tile_bus.pe_done && (out_q != '0);

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        s_d     = s_q;
        ncg_d   = ncg_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    w_d     = OFM_W;
                    s_d     = (stride == 2'd0) ? 2'd1 : stride;
                    ncg_d   = ncg_in;
                    state_d = ((OFM_W == '0) || (ncg_in == '0)) ? DONE : ISSUE;
                end
            end
            ISSUE:   if (handshake && idx_last) state_d = DRAIN;
            DRAIN:   if (out_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (handshake && !pe_dec) begin
            out_d = out_q + OUT_W'(1);
        end else if (!handshake && pe_dec) begin
            out_d = out_q - OUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            s_q     <= '0;
            ncg_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            s_q     <= s_d;
            ncg_q   <= ncg_d;
            out_q   <= out_d;
        end
    end

    tile_index_counter u_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (start_ok),
        .advance (handshake),
        .cfg_w   (w_q),
        .cfg_ncg (ncg_q),
        .col     (idx_col),
        .row     (idx_row),
        .cgrp    (idx_cgrp),
        .last    (idx_last)
    );

    assign tile_bus.tile_valid = (state_q == ISSUE) && !at_limit;
    assign tile_bus.tile_row   = idx_row;
    assign tile_bus.tile_col   = idx_col;
    assign tile_bus.tile_cgrp  = idx_cgrp;
    assign tile_bus.ifm_row    = IFM_IDX_W'(idx_row) * IFM_IDX_W'(s_q);
    assign tile_bus.ifm_col    = IFM_IDX_W'(idx_col) * IFM_IDX_W'(s_q);
    assign tile_bus.tile_last  = idx_last;
    assign outstanding         = out_q;
    assign busy                = (state_q == ISSUE) || (state_q == DRAIN);
    assign done                = (state_q == DONE);

`ifdef OFM_TILE_SCHED_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] throttle_q, throttle_d;

    always_comb begin
        stall_d    = stall_q;
        throttle_d = throttle_q;
        if (start_ok) begin
            stall_d    = '0;
            throttle_d = '0;
        end else begin
            if (tile_bus.tile_valid && !tile_bus.tile_ready && (stall_q != '1)) begin
                stall_d = stall_q + 32'd1;
            end
            if ((state_q == ISSUE) && at_limit && (throttle_q != '1)) begin
                throttle_d = throttle_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q    <= '0;
            throttle_q <= '0;
        end else begin
            stall_q    <= stall_d;
            throttle_q <= throttle_d;
        end
    end

    assign stall_cycles    = stall_q;
    assign throttle_cycles = throttle_q;
`endif

endmodule
`default_nettype wire
